// File: rtl/elevador.sv
// Five-floor elevator controller: one-hot requests, up/down motor commands,
// current/target floor tracking and a passenger counter that only moves while stopped.
module elevador #(
   parameter int TRAVEL_CYCLES = 2,
   parameter int MAX_PEOPLE    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] req,
   input  logic       person_enter,
   input  logic       person_exit,
   output logic       motor_up,
   output logic       motor_down,
   output logic [2:0] andar_atual,
   output logic [2:0] andar_requisitado,
   output logic [3:0] num_people
);

   localparam int CW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(TRAVEL_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [3:0]    PEOPLE_MAX = 4'(MAX_PEOPLE);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      MOVING_UP   = 2'd1,
      MOVING_DOWN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      floor_q, floor_d;
   logic [2:0]      target_q, target_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      people_q, people_d;
   logic            motor_up_q, motor_up_d;
   logic            motor_down_q, motor_down_d;
   logic [2:0]      cand_s;

   // Lowest set request bit wins when several floors are requested at once.
   function automatic logic [2:0] lowest_floor(input logic [4:0] r);
      logic [2:0] f;
      casez (r)
         5'b????1: f = 3'd0;
         5'b???10: f = 3'd1;
         5'b??100: f = 3'd2;
         5'b?1000: f = 3'd3;
         5'b10000: f = 3'd4;
         default:  f = 3'd0;
      endcase
      return f;
   endfunction

   assign cand_s = lowest_floor(req);

   // Next-state, floor stepping, passenger count and motor command logic.
   always_comb begin
      state_d  = state_q;
      floor_d  = floor_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      people_d = people_q;
      case (state_q)
         IDLE: begin
            cnt_d = CNT_ZERO;
            if ((req != 5'b00000) && (cand_s != floor_q)) begin
               target_d = cand_s;
               state_d  = (cand_s > floor_q) ? MOVING_UP : MOVING_DOWN;
            end else begin
               state_d = IDLE;
            end
            if (person_enter && !person_exit && (people_q < PEOPLE_MAX)) begin
               people_d = people_q + 4'd1;
            end else if (person_exit && !person_enter && (people_q != 4'd0)) begin
               people_d = people_q - 4'd1;
            end else begin
               people_d = people_q;
            end
         end
         MOVING_UP, MOVING_DOWN: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = CNT_ZERO;
               if (state_q == MOVING_UP) begin
                  floor_d = (floor_q < 3'd4) ? floor_q + 3'd1 : floor_q;
               end else begin
                  floor_d = (floor_q != 3'd0) ? floor_q - 3'd1 : floor_q;
               end
               if (floor_d == target_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = state_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
      motor_up_d   = (state_d == MOVING_UP);
      motor_down_d = (state_d == MOVING_DOWN);
   end

   // State and output registers; active-low synchronous reset aborts any trip.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         floor_q      <= 3'd0;
         target_q     <= 3'd0;
         cnt_q        <= CNT_ZERO;
         people_q     <= 4'd0;
         motor_up_q   <= 1'b0;
         motor_down_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         floor_q      <= floor_d;
         target_q     <= target_d;
         cnt_q        <= cnt_d;
         people_q     <= people_d;
         motor_up_q   <= motor_up_d;
         motor_down_q <= motor_down_d;
      end
   end

   assign motor_up          = motor_up_q;
   assign motor_down        = motor_down_q;
   assign andar_atual       = floor_q;
   assign andar_requisitado = target_q;
   assign num_people        = people_q;

endmodule

// File: tb/tb_elevador.sv
// Self-checking bench for elevador: directed test-plan walk plus random stimulus,
// compared each cycle against a trip-timer reference model.
module tb_elevador;

   localparam int T    = 2;
   localparam int MAXP = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] req = 5'b00000;
   logic       person_enter = 1'b0;
   logic       person_exit = 1'b0;
   logic       motor_up, motor_down;
   logic [2:0] andar_atual, andar_requisitado;
   logic [3:0] num_people;

   int checks = 0;
   int failures = 0;

   int m_floor, m_target, m_start, m_elapsed, m_people;
   bit m_moving;

   elevador #(.TRAVEL_CYCLES(T), .MAX_PEOPLE(MAXP)) dut (
      .clk(clk), .reset(reset), .req(req),
      .person_enter(person_enter), .person_exit(person_exit),
      .motor_up(motor_up), .motor_down(motor_down),
      .andar_atual(andar_atual), .andar_requisitado(andar_requisitado),
      .num_people(num_people)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   // Reference: position is start floor plus elapsed edges divided by travel time.
   task automatic model_step(input logic rst, input logic [4:0] r, input logic en, input logic ex);
      int cand;
      if (!rst) begin
         m_floor = 0; m_target = 0; m_start = 0; m_elapsed = 0; m_people = 0; m_moving = 0;
      end else if (!m_moving) begin
         if (en && !ex && m_people < MAXP) m_people++;
         else if (ex && !en && m_people > 0) m_people--;
         if (r != 5'b00000) begin
            cand = -1;
            for (int i = 4; i >= 0; i--) if (r[i]) cand = i;
            if (cand != m_floor) begin
               m_target = cand; m_start = m_floor; m_elapsed = 0; m_moving = 1;
            end
         end
      end else begin
         m_elapsed++;
         if (m_target > m_start) m_floor = m_start + m_elapsed / T;
         else m_floor = m_start - m_elapsed / T;
         if (m_floor == m_target) m_moving = 0;
      end
   endtask

   task automatic cyc(input logic rst, input logic [4:0] r, input logic en, input logic ex);
      reset = rst; req = r; person_enter = en; person_exit = ex;
      model_step(rst, r, en, ex);
      @(posedge clk);
      #1;
      check_eq("andar_atual", int'(andar_atual), m_floor);
      check_eq("andar_requisitado", int'(andar_requisitado), m_target);
      check_eq("motor_up", int'(motor_up), int'(m_moving && (m_target > m_start)));
      check_eq("motor_down", int'(motor_down), int'(m_moving && (m_target < m_start)));
      check_eq("num_people", int'(num_people), m_people);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 5'b00000, 1'b0, 1'b0);
   endtask

   initial begin
      logic [4:0] r;
      logic       rs, en, ex;
      int         sel;
      // reset held with a pending request, then release: accepted next edge
      cyc(1'b0, 5'b10000, 1'b0, 1'b0);
      cyc(1'b0, 5'b10000, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) cyc(1'b1, 5'b10000, 1'b0, 1'b0);
      cyc(1'b1, 5'b00000, 1'b1, 1'b0);
      cyc(1'b1, 5'b01000, 1'b0, 1'b0);
      idle_n(2);
      cyc(1'b1, 5'b00000, 1'b1, 1'b0);
      cyc(1'b1, 5'b00001, 1'b0, 1'b0);
      idle_n(6);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 5'b00000, 1'b0, 1'b1);
         idle_n(1);
      end
      for (int i = 0; i < MAXP + 2; i++) cyc(1'b1, 5'b00000, 1'b1, 1'b0);
      cyc(1'b1, 5'b00000, 1'b1, 1'b1);
      cyc(1'b1, 5'b10010, 1'b0, 1'b0);
      cyc(1'b1, 5'b00100, 1'b0, 1'b1);
      cyc(1'b1, 5'b01000, 1'b1, 1'b0);
      idle_n(1);
      cyc(1'b1, 5'b10000, 1'b0, 1'b0);
      idle_n(T * 1 + 1);
      cyc(1'b0, 5'b00000, 1'b0, 1'b0);
      idle_n(2);
      // random phase
      for (int n = 0; n < 3000; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 6) r = 5'b00000;
         else if (sel < 8) r = 5'(1 << $urandom_range(0, 4));
         else r = 5'($urandom_range(0, 31));
         rs = ($urandom_range(0, 199) != 0);
         en = ($urandom_range(0, 3) == 0);
         ex = ($urandom_range(0, 3) == 0);
         cyc(rs, r, en, ex);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
